// File: rtl/fifo_rd_pkg.sv
// Shared sizing and types for the FIFO read adapter and its skid buffer.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  // Occupancy 0..BUF_DEPTH
  typedef logic [1:0] level_t;
  // Index into the BUF_DEPTH-entry buffer
  typedef logic       ptr_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order skid buffer: head/tail pointers plus level counter.
// Storage is cleared on reset so the read port shows 0 after reset.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output level_t                level
);

  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  ptr_t head;
  ptr_t tail;

  assign rd_data = mem[head];

  // Storage, pointers and occupancy; simultaneous write and read keep the level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= tail + 1'b1;
      end
      if (rd_en) head <= head + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_adapter.sv
// FIFO read port (1-cycle read latency) to valid/ready stream adapter.
// Reads are only issued when the word is guaranteed a slot in the skid buffer,
// counting the word already in flight and any pop happening this cycle.
// Optional: define FIFO_RD_ADAPTER_STATS_EN to add xfer_count_o (pop counter).
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
`ifdef FIFO_RD_ADAPTER_STATS_EN
  output logic [31:0]           xfer_count_o,
`endif
  output logic [1:0]            buf_level_o
);

  logic       inflight;
  logic       pop;
  level_t     level;
  logic [2:0] credit;

  // Outputs are forced idle while reset is held, even before the first edge clears state.
  assign m_valid_o   = !rst_i && (level != '0);
  assign buf_level_o = rst_i ? '0 : level;
  assign pop         = m_valid_o && m_ready_i;

  // Slots committed after this cycle: stored + arriving - leaving.
  assign credit       = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en_o = !rst_i && !fifo_empty_i && (credit < 3'(BUF_DEPTH));

  // In-flight bit: the FIFO presents data the cycle after a pop request.
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight <= 1'b0;
    else       inflight <= fifo_rd_en_o;
  end

  rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (inflight),
    .wr_data (fifo_data_i),
    .rd_en   (pop),
    .rd_data (m_data_o),
    .level   (level)
  );

`ifdef FIFO_RD_ADAPTER_STATS_EN
  // Transfer counter, wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i)    xfer_count_o <= '0;
    else if (pop) xfer_count_o <= xfer_count_o + 32'd1;
  end
`endif

endmodule

// File: doc/fifo_rd_adapter.md
FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the FIFO data word and the stream data word.
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports clk_i and rst_i.
REQ-003 clk_i  input  1  single clock for the adapter and the attached FIFO read port.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 fifo_data_i  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en_o.
REQ-006 fifo_empty_i  input  1  FIFO empty flag.
REQ-007 fifo_rd_en_o  output  1  FIFO pop request.
REQ-008 m_data_o  output  DATA_WIDTH  stream data.
REQ-009 m_valid_o  output  1  stream data valid.
REQ-010 m_ready_i  input  1  downstream ready.
REQ-011 buf_level_o  output  2  skid buffer occupancy, 0..2.

Function
REQ-012 SHALL convert the FIFO read port into a valid/ready stream, reading the FIFO through its fixed 1-cycle read latency.
REQ-013 SHALL hold a 2-entry skid buffer (BUF_DEPTH=2), in-order, with a head pointer, a tail pointer and a level counter.
REQ-014 SHALL track one in-flight bit: set the cycle after fifo_rd_en_o=1, cleared otherwise.
REQ-015 Word capture: a word SHALL be written into the buffer on every cycle the in-flight bit is 1.
REQ-016 pop = m_valid_o && m_ready_i.
REQ-017 fifo_rd_en_o = !fifo_empty_i && (level + inflight - pop) < 2, so the FIFO is never read when the word cannot be stored; pop is a combinational term.
REQ-018 Throughput: with the FIFO non-empty and m_ready_i=1, SHALL sustain one word per cycle after a 2-cycle initial latency (rd_en, then capture, then m_valid_o).
REQ-019 m_valid_o = (level != 0); m_data_o = buffer[head].
REQ-020 SHALL keep m_data_o stable while m_valid_o=1 and m_ready_i=0.
REQ-021 Simultaneous capture and pop SHALL leave the level unchanged; both pointers advance.
REQ-022 Pointers SHALL wrap modulo 2.
REQ-023 Level SHALL never exceed 2; overflow is unreachable by REQ-017.
REQ-024 When fifo_empty_i=1, fifo_rd_en_o SHALL be 0 regardless of space.
REQ-025 Output order SHALL equal FIFO order, with no loss or duplication outside reset.

Reset
REQ-026 While rst_i=1: level=0, pointers=0, inflight=0, m_valid_o=0, fifo_rd_en_o=0, buf_level_o=0.
REQ-027 m_data_o reset value SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard buffered and in-flight words; a word popped from the FIFO in the cycle before reset is lost (system-level responsibility).

Configuration
REQ-029 Macro FIFO_RD_ADAPTER_STATS_EN, when defined, SHALL add output xfer_count_o [31:0]:
- increments on each pop;
- wraps at 2^32;
- resets to 0 by rst_i.
REQ-030 Without the macro the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package fifo_rd_pkg SHALL hold BUF_DEPTH=2, the level typedef (2 bits) and the pointer typedef (1 bit).
REQ-032 The buffer storage and pointers SHALL be a sub-module rd_skid_buf; the credit/read logic stays in fifo_rd_adapter.

Verification
REQ-033 Reset: hold rst_i 3 cycles with fifo_empty_i=0 -> fifo_rd_en_o=0, m_valid_o=0, buf_level_o=0 throughout.
REQ-034 Streaming: FIFO holds 0x1..0x8, m_ready_i=1 -> first m_valid_o 2 cycles after reset release, then 0x1..0x8 on consecutive cycles.
REQ-035 Backpressure: m_ready_i=0 with the FIFO holding 5 words -> exactly 2 fifo_rd_en_o pulses, buf_level_o=2, m_data_o stable at word 0; release -> remaining words in order.
REQ-036 Empty boundary: one word 0xA5, then fifo_empty_i=1 -> single rd_en pulse, 0xA5 delivered, then m_valid_o=0 and no further rd_en.
REQ-037 Random ready (50%) over 1000 words -> scoreboard matches in order, level never >2, with FIFO_RD_ADAPTER_STATS_EN xfer_count_o=1000.
REQ-038 Mid-stream reset with level=2 -> next cycle m_valid_o=0, buf_level_o=0; streaming resumes with the next FIFO word.
